// File: rtl/eth_rx_framer.sv
// Byte-wide Ethernet receive framer: preamble/SFD search, MAC header capture,
// destination filtering, FCS stripping through a 4-byte delay line, CRC-32 check.
module eth_rx_framer #(
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC     = 1'b0,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  output logic [7:0]  frame_out,
  output logic        valid,
  output logic        sof,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        done,
  output logic [10:0] payload_len,
  output logic        crc_err,
  output logic        runt,
  output logic        too_long,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;
  localparam logic [10:0] MAX_LEN     = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_LEN     = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [31:0] dly_q, dly_d;
  logic [2:0]  dly_cnt_q, dly_cnt_d;
  logic [10:0] len_q, len_d;
  logic        over_q, over_d;

  logic [7:0]  frame_out_q, frame_out_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        done_q, done_d;
  logic [10:0] plen_q, plen_d;
  logic        crc_err_q, crc_err_d;
  logic        runt_q, runt_d;
  logic        too_long_q, too_long_d;

  logic        addr_match;

  assign addr_match = PROMISC || (dst_q == MAC_ADDR) || (dst_q == BCAST_ADDR);

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    crc_d       = crc_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    dly_d       = dly_q;
    dly_cnt_d   = dly_cnt_q;
    len_d       = len_q;
    over_d      = over_q;
    frame_out_d = 8'h00;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    done_d      = 1'b0;
    plen_d      = 11'd0;
    crc_err_d   = 1'b0;
    runt_d      = 1'b0;
    too_long_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          state_d = (rx_data == PRE_BYTE) ? S_PRE : S_DROP;
        end
      end

      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_d   = S_HDR;
          hdr_cnt_d = 4'd0;
          crc_d     = CRC_INIT;
        end else if (rx_data != PRE_BYTE) begin
          state_d = S_DROP;
        end
      end

      S_HDR: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else begin
          crc_d     = crc32_byte(crc_q, rx_data);
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q < 4'd6) begin
            dst_d = {dst_q[39:0], rx_data};
          end else if (hdr_cnt_q < 4'd12) begin
            src_d = {src_q[39:0], rx_data};
          end else begin
            type_d = {type_q[7:0], rx_data};
          end
          // dst_q is complete by byte 13, so the filter can look at it directly.
          if (hdr_cnt_q == 4'd13) begin
            state_d   = addr_match ? S_PAY : S_DROP;
            dly_cnt_d = 3'd0;
            len_d     = 11'd0;
            over_d    = 1'b0;
          end
        end
      end

      S_PAY: begin
        if (rx_dv) begin
          crc_d = crc32_byte(crc_q, rx_data);
          dly_d = {dly_q[23:0], rx_data};
          if (dly_cnt_q != 3'd4) begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end else if (len_q != MAX_LEN) begin
            frame_out_d = dly_q[31:24];
            valid_d     = 1'b1;
            sof_d       = (len_q == 11'd0);
            len_d       = len_q + 11'd1;
          end else begin
            over_d = 1'b1;
          end
        end else begin
          // The four bytes still in the delay line are the FCS and are discarded.
          state_d    = S_IDLE;
          done_d     = 1'b1;
          plen_d     = len_q;
          crc_err_d  = (crc_q != CRC_RESIDUE);
          runt_d     = (len_q < MIN_LEN);
          too_long_d = over_q;
        end
      end

      S_DROP: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= 4'd0;
      crc_q       <= 32'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      dly_q       <= 32'd0;
      dly_cnt_q   <= 3'd0;
      len_q       <= 11'd0;
      over_q      <= 1'b0;
      frame_out_q <= 8'h00;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      done_q      <= 1'b0;
      plen_q      <= 11'd0;
      crc_err_q   <= 1'b0;
      runt_q      <= 1'b0;
      too_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      crc_q       <= crc_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      len_q       <= len_d;
      over_q      <= over_d;
      frame_out_q <= frame_out_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      done_q      <= done_d;
      plen_q      <= plen_d;
      crc_err_q   <= crc_err_d;
      runt_q      <= runt_d;
      too_long_q  <= too_long_d;
    end
  end

  assign frame_out   = frame_out_q;
  assign valid       = valid_q;
  assign sof         = sof_q;
  assign dst_mac     = dst_q;
  assign src_mac     = src_q;
  assign ethertype   = type_q;
  assign done        = done_q;
  assign payload_len = plen_q;
  assign crc_err     = crc_err_q;
  assign runt        = runt_q;
  assign too_long    = too_long_q;
  assign dbg_state   = state_q;

endmodule
